// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: one-cycle logic/arith ops, iterative shift-left,
// optional iterative multiplier enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  // Counter must hold both a 5-bit shift amount and the XLEN multiply step count
  localparam int CW = ($clog2(XLEN + 1) > 5) ? $clog2(XLEN + 1) : 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd3;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] quickRes;
  logic            quickIll;
  logic [4:0]      shAmt;
  logic [XLEN-1:0] accShl;

`ifdef ALU_EXEC_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0] prodSum;

  assign prodSum = prod_q + (acc_q[0] ? mcand_q : '0);
`endif

  assign shAmt  = op_b[4:0];
  assign accShl = acc_q << 1;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Single-cycle result; SLL yields op_a here, which is the answer for a zero amount
  always_comb begin
    quickRes = '0;
    quickIll = 1'b0;
    case (alu_control)
      OP_AND:  quickRes = op_a & op_b;
      OP_OR:   quickRes = op_a | op_b;
      OP_ADD:  quickRes = op_a + op_b;
      OP_SUB:  quickRes = op_a - op_b;
      OP_SLT:  quickRes = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  quickRes = op_a;
      OP_NOP:  quickRes = '0;
`ifdef ALU_EXEC_MUL_EN
      OP_MUL:  quickRes = '0;
`endif
      default: quickIll = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d   = mcand_q;
    prod_d    = prod_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_control == OP_SLL && shAmt != 5'd0) begin
            acc_d   = op_a;
            cnt_d   = CW'(shAmt);
            state_d = SHIFT;
          end
`ifdef ALU_EXEC_MUL_EN
          else if (alu_control == OP_MUL) begin
            mcand_d = op_a;
            acc_d   = op_b;
            prod_d  = '0;
            cnt_d   = CW'(XLEN - 1);
            state_d = MUL;
          end
`endif
          else begin
            result_d  = quickRes;
            zero_d    = (quickRes == '0);
            illegal_d = quickIll;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = accShl;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d  = accShl;
          zero_d    = (accShl == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      // acc holds the multiplier, consumed LSB first while the multiplicand walks left
      MUL: begin
        prod_d  = prodSum;
        mcand_d = mcand_q << 1;
        acc_d   = acc_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d  = prodSum;
          zero_d    = (prodSum == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q   <= '0;
      prod_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
`endif
    end
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute stage that consumes the 4-bit ALU operation code produced by the decode-side ALU control logic and computes the result. Operands and code are accepted with a valid/ready handshake, and the result is returned with a second valid/ready handshake. Logic ops, add, sub and set-less-than complete in one cycle. Shift-left is iterative, one bit per cycle, and an optional iterative multiplier is available. The block sits between register-read and writeback in the CPU datapath.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands and code present.
- `in_ready` output 1: unit can accept a new operation.
- `alu_control` input 4: operation code.
- `op_a` input XLEN: first operand.
- `op_b` input XLEN: second operand or shift amount.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `result` output XLEN: operation result.
- `zero` output 1: high when `result == 0`.
- `illegal` output 1: the code was not recognised.

## Operation
- Codes:
  - 0000: AND.
  - 0001: OR.
  - 0010: ADD, modulo 2^XLEN.
  - 0110: SUB, modulo 2^XLEN.
  - 0111: SLT, signed compare, result 1 or 0.
  - 1110: SLL by `op_b[4:0]`; upper bits of `op_b` are ignored.
  - 1111: NOP, result 0, not illegal.
  - 1000: MUL, only with the macro enabled (see Configuration).
- Any other code gives `result` 0, `zero` 1, `illegal` 1, in a single cycle.
- FSM states are IDLE, SHIFT, MUL and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch `alu_control`, `op_a` and `op_b`.
  - Single-cycle ops, and SLL with amount 0: compute and go to DONE.
  - SLL with amount > 0: load an accumulator with `op_a` and a counter with the amount, then go to SHIFT.
  - MUL: go to MUL.
- SHIFT: each cycle shift the accumulator left by 1 and decrement the counter. When the counter reaches 0, go to DONE.
- MUL: shift-add over XLEN cycles, one multiplier bit per cycle, LSB first. Keep the low XLEN bits of the product. Go to DONE after the XLEN-th step.
- DONE:
  - `out_valid` = 1.
  - `result`, `zero` and `illegal` are registered and stable until `out_ready` is sampled high.
  - On `out_ready`, return to IDLE.
- `in_ready` is 0 in every state except IDLE, so there is no overlap between operations.
- Outputs are registered, not combinational from the inputs.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `zero` 1, `illegal` 0.
- Reset is asynchronous. Asserting `rst` mid-operation, in any state, aborts the operation immediately; the partial result is discarded.
- Latency from the accept edge to `out_valid` high:
  - Single-cycle ops: 1 cycle.
  - SLL by n: 1 + n cycles.
  - MUL: 1 + XLEN cycles.
- Minimum spacing between accepts is 2 cycles: accept, then DONE with `out_ready` already high.
- `out_ready` held low stalls the unit in DONE indefinitely, with outputs unchanged.
- Inputs are ignored in any state other than IDLE.
- `in_valid` and `out_ready` arriving together: the DONE→IDLE transition completes first. The new operation is accepted no earlier than the next cycle.

## Configuration
- Macro: `ALU_EXEC_MUL_EN`.
- Defined:
  - Code 1000 is a valid MUL using the MUL state; `illegal` 0.
  - The multiplicand and product registers are present.
- Undefined:
  - The MUL state and its registers are removed.
  - Code 1000 is handled as illegal: result 0, `illegal` 1, single cycle.

## Test plan
- Reset with `rst` high, then release: `in_ready` 1, `out_valid` 0, `result` 0, `zero` 1.
- SUB 5−5 → `out_valid` one cycle after the accept, `result` 0, `zero` 1.
- SLT 0xFFFFFFFF vs 1 → `result` 1.
- SLL 1 by 31 → `out_valid` 32 cycles after the accept, `result` 0x80000000.
- SLL with amount 0 → 1-cycle latency, `result` equals `op_a`.
- ADD 7+8 with `out_ready` held low for 5 cycles:
  - `result` 15 stable throughout, `in_ready` 0.
  - `in_valid` pulses during the stall are ignored.
- Assert `rst` during SLL by 20, then release:
  - State returns to IDLE with no `out_valid` pulse.
  - The next ADD 2+3 returns 5.
- MUL 0x10000 × 0x10000 with `ALU_EXEC_MUL_EN` defined → latency 33, `result` 0, `zero` 1.
- Code 1000 with `ALU_EXEC_MUL_EN` undefined → `illegal` 1, `result` 0.
- Code 0011 → `illegal` 1, `result` 0.
